ext_pipe_unit: RTL and testbench

Parametrised, registered immediate-extension stage for the datapath's pipelined successor. Takes an IMM_WIDTH-bit immediate plus a 2-bit extension mode and produces an OUT_WIDTH-bit operand. Offers zero, sign, upper-placement and branch-offset modes. Inputs and outputs use valid/ready handshakes, with a 2-entry output buffer that absorbs downstream stalls without dropping or reordering operands.

---
 rtl/ext_pkg.sv | 21 ++
 rtl/ext_pipe_unit_if.sv | 34 +++
 rtl/ext_core.sv | 35 +++
 rtl/ext_pipe_unit.sv | 82 ++++++++
 tb/tb_ext_pipe_unit.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ext_pkg.sv
// ext_pkg: shared definitions for the immediate-extension pipeline stage.
//   ext_op_e      - 2-bit extension mode (zero / sign / upper / branch)
//   FifoDepth     - number of output buffer entries
//   imm_width_ok  - legal-parameter predicate used at elaboration
package ext_pkg;

    typedef enum logic [1:0] {
        EXT_ZERO   = 2'b00,
        EXT_SIGN   = 2'b01,
        EXT_UPPER  = 2'b10,
        EXT_BRANCH = 2'b11
    } ext_op_e;

    localparam int unsigned FifoDepth = 2;

    // The branch mode needs two spare bits above the sign-extended immediate.
    function automatic bit imm_width_ok(int unsigned imm_w, int unsigned out_w);
        return (imm_w >= 1) && (imm_w + 2 <= out_w);
    endfunction

endpackage

// File: rtl/ext_pipe_unit_if.sv
// ext_pipe_unit_if: valid/ready handshake bundle for the extension stage.
//   Input side : in_valid, in_ready, in_imm, in_mode, in_tag
//   Output side: out_valid, out_ready, out_data, out_tag, out_count
//   modport master - producer/consumer environment driving the unit
//   modport slave  - the extension unit itself
interface ext_pipe_unit_if #(
    parameter int unsigned IMM_WIDTH = 16,
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned TAG_WIDTH = 5
);
    import ext_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [IMM_WIDTH-1:0] in_imm;
    ext_op_e              in_mode;
    logic [TAG_WIDTH-1:0] in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic [TAG_WIDTH-1:0] out_tag;
    logic [1:0]           out_count;

    modport master (
        output in_valid, in_imm, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_count
    );

    modport slave (
        input  in_valid, in_imm, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_count
    );

endinterface

// File: rtl/ext_core.sv
// ext_core: purely combinational immediate extender.
//   imm  - IMM_WIDTH-bit raw immediate
//   mode - extension mode (ext_op_e)
//   data - OUT_WIDTH-bit extended operand
module ext_core
    import ext_pkg::*;
#(
    parameter int unsigned IMM_WIDTH = 16,
    parameter int unsigned OUT_WIDTH = 32
) (
    input  logic [IMM_WIDTH-1:0] imm,
    input  ext_op_e              mode,
    output logic [OUT_WIDTH-1:0] data
);

    localparam int unsigned PadWidth = OUT_WIDTH - IMM_WIDTH;

    logic [OUT_WIDTH-1:0] zext;
    logic [OUT_WIDTH-1:0] sext;

    assign zext = {{PadWidth{1'b0}}, imm};
    assign sext = {{PadWidth{imm[IMM_WIDTH-1]}}, imm};

    always_comb begin
        data = zext;
        case (mode)
            EXT_ZERO:   data = zext;
            EXT_SIGN:   data = sext;
            EXT_UPPER:  data = {imm, {PadWidth{1'b0}}};
            // Top two sign bits fall off; the offset becomes word-aligned.
            EXT_BRANCH: data = {sext[OUT_WIDTH-3:0], 2'b00};
        endcase
    end

endmodule

// File: rtl/ext_pipe_unit.sv
// ext_pipe_unit: registered immediate-extension stage with a 2-entry output FIFO.
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset (clears count, pointer and storage)
//   flush - synchronous discard of all buffered entries; beats push and pop
//   bus   - ext_pipe_unit_if.slave: input handshake (imm/mode/tag) and
//           output handshake (data/tag/count)
module ext_pipe_unit
    import ext_pkg::*;
#(
    parameter int unsigned IMM_WIDTH = 16,
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned TAG_WIDTH = 5
) (
    input logic            clk,
    input logic            rst_n,
    input logic            flush,
    ext_pipe_unit_if.slave bus
);

    if (!imm_width_ok(IMM_WIDTH, OUT_WIDTH)) begin : g_bad_params
        $error("ext_pipe_unit: IMM_WIDTH must lie in 1..OUT_WIDTH-2");
    end

    logic [OUT_WIDTH-1:0] ext_data;
    logic [OUT_WIDTH-1:0] data_q [FifoDepth];
    logic [TAG_WIDTH-1:0] tag_q  [FifoDepth];
    logic                 head_q;
    logic [1:0]           count_q;

    logic in_ready;
    logic out_valid;
    logic push;
    logic pop;
    logic tail;

    ext_core #(
        .IMM_WIDTH (IMM_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_core (
        .imm  (bus.in_imm),
        .mode (bus.in_mode),
        .data (ext_data)
    );

    // in_ready depends on registers only, so out_ready never reaches it.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;
    // Write slot is head + count (mod 2); only used while count < 2.
    assign tail      = head_q ^ count_q[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
            for (int i = 0; i < FifoDepth; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (flush) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
        end else begin
            if (push) begin
                data_q[tail] <= ext_data;
                tag_q[tail]  <= bus.in_tag;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = data_q[head_q];
    assign bus.out_tag   = tag_q[head_q];
    assign bus.out_count = count_q;

endmodule

// File: tb/tb_ext_pipe_unit.sv
// tb_ext_pipe_unit: scoreboard bench for ext_pipe_unit (default widths) plus a
// second instance with IMM_WIDTH=12 for the parameter sweep.
module tb_ext_pipe_unit;
    import ext_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  tag;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    ext_pipe_unit_if #(.IMM_WIDTH(16), .OUT_WIDTH(32), .TAG_WIDTH(5)) bus ();
    ext_pipe_unit_if #(.IMM_WIDTH(12), .OUT_WIDTH(32), .TAG_WIDTH(5)) bus12 ();

    ext_pipe_unit #(.IMM_WIDTH(16), .OUT_WIDTH(32), .TAG_WIDTH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    ext_pipe_unit #(.IMM_WIDTH(12), .OUT_WIDTH(32), .TAG_WIDTH(5)) dut12 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (1'b0),
        .bus   (bus12)
    );

    int checks   = 0;
    int failures = 0;

    exp_t        q[$];
    logic [31:0] q12[$];
    exp_t        mon_e;
    logic [31:0] mon12_e;

    logic [15:0] s_imm  [8];
    ext_op_e     s_mode [8];
    logic [31:0] s_exp  [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand and records its expected result once it will be accepted.
    task automatic push(input logic [15:0] imm, input ext_op_e mode, input logic [4:0] tag,
                        input logic [31:0] exp);
        exp_t e;
        bit   done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_imm   = imm;
        bus.in_mode  = mode;
        bus.in_tag   = tag;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.data = exp;
                e.tag  = tag;
                q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL push_timeout tag=%0d actual=in_ready_low required=accept", tag);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic push12(input logic [11:0] imm, input ext_op_e mode, input logic [31:0] exp);
        bit done;
        done = 1'b0;
        bus12.in_valid = 1'b1;
        bus12.in_imm   = imm;
        bus12.in_mode  = mode;
        bus12.in_tag   = 5'd0;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (bus12.in_ready) begin
                q12.push_back(exp);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL push12_timeout actual=in_ready_low required=accept");
        end
        bus12.in_valid = 1'b0;
    endtask

    // Monitor: every handshake on the output side pops and compares the scoreboard.
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=%h/tag%0d required=no_output",
                         bus.out_data, bus.out_tag);
            end else begin
                mon_e = q.pop_front();
                check("sb_data", bus.out_data, mon_e.data);
                check("sb_tag", 32'(bus.out_tag), 32'(mon_e.tag));
            end
        end
    end

    always @(negedge clk) begin
        if (bus12.out_valid && bus12.out_ready) begin
            if (q12.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sweep_unexpected actual=%h required=no_output", bus12.out_data);
            end else begin
                mon12_e = q12.pop_front();
                check("sweep_data", bus12.out_data, mon12_e);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        s_imm  = '{16'h0001, 16'h0002, 16'hFFFE, 16'h00FF,
                   16'h8000, 16'h0003, 16'hABCD, 16'hABCD};
        s_mode = '{EXT_ZERO, EXT_SIGN, EXT_SIGN, EXT_UPPER,
                   EXT_BRANCH, EXT_BRANCH, EXT_ZERO, EXT_SIGN};
        s_exp  = '{32'h00000001, 32'h00000002, 32'hFFFFFFFE, 32'h00FF0000,
                   32'hFFFE0000, 32'h0000000C, 32'h0000ABCD, 32'hFFFFABCD};

        bus.in_valid    = 1'b0;
        bus.in_imm      = '0;
        bus.in_mode     = EXT_ZERO;
        bus.in_tag      = '0;
        bus.out_ready   = 1'b0;
        bus12.in_valid  = 1'b0;
        bus12.in_imm    = '0;
        bus12.in_mode   = EXT_ZERO;
        bus12.in_tag    = '0;
        bus12.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_tag", 32'(bus.out_tag), 32'd0);
        check("rst_out_count", 32'(bus.out_count), 32'd0);
        rst_n = 1'b1;

        // Basic modes, one cycle latency
        bus.out_ready = 1'b1;
        push(16'h8001, EXT_ZERO, 5'd1, 32'h00008001);
        check("latency_valid", 32'(bus.out_valid), 32'd1);
        push(16'h8001, EXT_SIGN, 5'd2, 32'hFFFF8001);
        push(16'h7FFF, EXT_SIGN, 5'd3, 32'h00007FFF);
        push(16'h1234, EXT_UPPER, 5'd4, 32'h12340000);
        push(16'hFFFF, EXT_BRANCH, 5'd5, 32'hFFFFFFFC);
        push(16'h4000, EXT_BRANCH, 5'd6, 32'h00010000);
        check("stream_count_basic", 32'(bus.out_count), 32'd1);
        tick();
        tick();
        check("idle_valid", 32'(bus.out_valid), 32'd0);
        check("idle_count", 32'(bus.out_count), 32'd0);

        // Backpressure: fill, hold tag 3 at the producer, then drain
        bus.out_ready = 1'b0;
        push(16'h0011, EXT_ZERO, 5'd1, 32'h00000011);
        push(16'h0022, EXT_ZERO, 5'd2, 32'h00000022);
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        check("bp_count_full", 32'(bus.out_count), 32'd2);
        check("bp_head_tag", 32'(bus.out_tag), 32'd1);
        fork
            push(16'h0033, EXT_ZERO, 5'd3, 32'h00000033);
            begin
                bus.out_ready = 1'b1;
                @(negedge clk);
                check("bp_count_seq0", 32'(bus.out_count), 32'd2);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                @(negedge clk);
                check("bp_hold_tag", 32'(bus.out_tag), 32'd2);
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
                @(negedge clk);
                check("bp_count_seq1", 32'(bus.out_count), 32'd2);
                @(negedge clk);
                check("bp_count_seq2", 32'(bus.out_count), 32'd1);
                @(negedge clk);
                check("bp_count_seq3", 32'(bus.out_count), 32'd0);
                check("bp_drained_valid", 32'(bus.out_valid), 32'd0);
            end
        join
        tick();

        // Streaming: 8 back-to-back operands, occupancy stays 1
        fork
            for (int i = 0; i < 8; i++) begin
                push(s_imm[i], s_mode[i], 5'(i + 8), s_exp[i]);
            end
            begin
                @(posedge clk);
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    check("stream_count", 32'(bus.out_count), 32'd1);
                    check("stream_valid", 32'(bus.out_valid), 32'd1);
                end
            end
        join
        tick();
        tick();

        // Flush at count 2 with a refused push
        bus.out_ready = 1'b0;
        push(16'h0044, EXT_ZERO, 5'd4, 32'h00000044);
        push(16'h0045, EXT_ZERO, 5'd5, 32'h00000045);
        flush         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_imm    = 16'h0055;
        bus.in_mode   = EXT_ZERO;
        bus.in_tag    = 5'd6;
        @(posedge clk);
        q.delete();
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush2_valid", 32'(bus.out_valid), 32'd0);
        check("flush2_count", 32'(bus.out_count), 32'd0);
        check("flush2_in_ready", 32'(bus.in_ready), 32'd1);

        // Flush at count 1 with an accepted push that must be discarded
        push(16'h0066, EXT_ZERO, 5'd7, 32'h00000066);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_imm   = 16'h0077;
        bus.in_tag   = 5'd8;
        @(posedge clk);
        q.delete();
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush1_count", 32'(bus.out_count), 32'd0);
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check("flush_idle_valid", 32'(bus.out_valid), 32'd0);
        push(16'h0088, EXT_ZERO, 5'd9, 32'h00000088);
        tick();

        // Reset mid-transfer at count 1
        bus.out_ready = 1'b0;
        push(16'h0099, EXT_SIGN, 5'd10, 32'h00000099);
        check("pre_rst_count", 32'(bus.out_count), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        q.delete();
        #1;
        rst_n = 1'b1;
        check("rst2_valid", 32'(bus.out_valid), 32'd0);
        check("rst2_data", bus.out_data, 32'd0);
        check("rst2_tag", 32'(bus.out_tag), 32'd0);
        check("rst2_count", 32'(bus.out_count), 32'd0);
        check("rst2_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        push(16'h0001, EXT_SIGN, 5'd11, 32'h00000001);
        tick();
        tick();

        // Parameter sweep: IMM_WIDTH=12
        bus12.out_ready = 1'b1;
        push12(12'h800, EXT_SIGN, 32'hFFFFF800);
        push12(12'h800, EXT_UPPER, 32'h80000000);
        push12(12'h800, EXT_ZERO, 32'h00000800);
        push12(12'h800, EXT_BRANCH, 32'hFFFFE000);
        tick();
        tick();

        check("sb_drain", 32'(q.size()), 32'd0);
        check("sweep_drain", 32'(q12.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
